// File: rtl/wallace_mac_pkg.sv
// wallace_mac_pkg: shared FSM encoding and width defaults for wallace_mac
package wallace_mac_pkg;
    localparam int OP_W      = 16;
    localparam int ACC_W_DEF = 40;
    localparam int CNT_W_DEF = 8;
    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        HOLD  = 2'd2
    } state_t;
endpackage

// File: rtl/wallace_mul.sv
// wallace_mul: combinational 16x16 unsigned Wallace-tree multiplier
// Ports: rst_n forces q to 0 while low; number1/number0 operands; q 32-bit product.
module wallace_mul (
    input  logic        rst_n,
    input  logic [15:0] number1,
    input  logic [15:0] number0,
    output logic [31:0] q
);
    // Row count after each 3:2 compression layer: 16 partial products down to 2.
    localparam int R [7] = '{16, 11, 8, 6, 4, 3, 2};
    logic [31:0] rows [7][16];
    always_comb begin
        for (int i = 0; i < 16; i++) rows[0][i] = number0[i] ? {16'd0, number1} << i : 32'd0;
        for (int s = 0; s < 6; s++) begin
            for (int j = 0; j < 16; j++) rows[s+1][j] = 32'd0;
            for (int g = 0; g < 5; g++) begin
                if (g < R[s] / 3) begin
                    rows[s+1][2*g]   = rows[s][3*g] ^ rows[s][3*g+1] ^ rows[s][3*g+2];
                    rows[s+1][2*g+1] = ((rows[s][3*g] & rows[s][3*g+1]) |
                                        (rows[s][3*g] & rows[s][3*g+2]) |
                                        (rows[s][3*g+1] & rows[s][3*g+2])) << 1;
                end
            end
            // Rows that do not fill a full group of three pass straight through.
            for (int k = 0; k < 2; k++) begin
                if (k < R[s] % 3) rows[s+1][2*(R[s]/3)+k] = rows[s][3*(R[s]/3)+k];
            end
        end
        q = rst_n ? rows[6][0] + rows[6][1] : 32'd0;
    end
endmodule

// File: rtl/wallace_mac.sv
// wallace_mac: streaming multiply-accumulate producing one dot product per in_last-terminated vector
// Ports: clk/rst (async high); in_valid/in_ready/number1/number0/in_last operand stream;
// out_valid/out_ready result handshake; acc_out sum, cnt_out term count, acc_ovf sticky wrap flag.
module wallace_mac
    import wallace_mac_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OP_W-1:0]  number1,
    input  logic [OP_W-1:0]  number0,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] acc_out,
    output logic [CNT_W-1:0] cnt_out,
    output logic             acc_ovf
);
    state_t state, state_nxt;
    logic [OP_W-1:0] s1_n1, s1_n0;
    logic s1_valid, accept, done;
    logic [2*OP_W-1:0] q;
    logic [ACC_W:0] sum;
    assign in_ready  = state == RUN;
    assign out_valid = state == HOLD;
    assign accept    = in_valid & in_ready;
    assign done      = out_valid & out_ready;
    assign sum       = {1'b0, acc_out} + (ACC_W+1)'(q);
    always_comb begin
        state_nxt = state;
        case (state)
            RUN:     state_nxt = (accept && in_last) ? DRAIN : RUN;
            DRAIN:   state_nxt = HOLD;
            HOLD:    state_nxt = done ? RUN : HOLD;
            default: state_nxt = RUN;
        endcase
    end
    wallace_mul u_mul (
        .rst_n   (~rst),
        .number1 (s1_n1),
        .number0 (s1_n0),
        .q       (q)
    );
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= RUN;
            s1_valid <= 1'b0;
            s1_n1    <= '0;
            s1_n0    <= '0;
            acc_out  <= '0;
            cnt_out  <= '0;
            acc_ovf  <= 1'b0;
        end else begin
            state    <= state_nxt;
            s1_valid <= accept;
            if (accept) begin
                s1_n1 <= number1;
                s1_n0 <= number0;
            end
            // s1_valid is never set in HOLD, so clearing and accumulating cannot collide.
            if (done) begin
                acc_out <= '0;
                cnt_out <= '0;
                acc_ovf <= 1'b0;
            end else if (s1_valid) begin
                acc_out <= sum[ACC_W-1:0];
                cnt_out <= cnt_out + CNT_W'(1);
                acc_ovf <= acc_ovf | sum[ACC_W];
            end
        end
    end
endmodule

// File: tb/tb_wallace_mac.sv
// tb_wallace_mac: randomized self-checking bench for wallace_mac (default and 32-bit accumulator)
module tb_wallace_mac;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    logic        out_ready = 1'b1;
    logic [15:0] number1 = '0;
    logic [15:0] number0 = '0;
    logic        rdy_a, rdy_b, ov_a, ov_b, ovf_a, ovf_b;
    logic [39:0] acc_a;
    logic [31:0] acc_b;
    logic [7:0]  cnt_a, cnt_b;
    int checks = 0;
    int errors = 0;
    logic [15:0] op1 [300];
    logic [15:0] op0 [300];

    wallace_mac dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_a),
        .number1(number1), .number0(number0), .in_last(in_last),
        .out_valid(ov_a), .out_ready(out_ready),
        .acc_out(acc_a), .cnt_out(cnt_a), .acc_ovf(ovf_a)
    );
    wallace_mac #(.ACC_W(32)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_b),
        .number1(number1), .number0(number0), .in_last(in_last),
        .out_valid(ov_b), .out_ready(out_ready),
        .acc_out(acc_b), .cnt_out(cnt_b), .acc_ovf(ovf_b)
    );

    always #5 clk = ~clk;

    // Reference: the result is the plain sum of products; a width-W accumulator
    // wraps at least once exactly when that sum reaches 2^W.
    task automatic drive_vector(input string name, input int n, input int hold);
        longint unsigned sum;
        logic [39:0] e40;
        logic [31:0] e32;
        logic eo40, eo32;
        sum = 0;
        out_ready = (hold == 0);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            checks++;
            if (rdy_a !== 1'b1 || rdy_b !== 1'b1 || ov_a !== 1'b0 || ov_b !== 1'b0) begin
                errors++;
                $display("FAIL %s beat%0d ready: got rdy=%b/%b ov=%b/%b expected rdy=1 ov=0", name, i, rdy_a, rdy_b, ov_a, ov_b);
            end
            in_valid = 1'b1;
            number1 = op1[i];
            number0 = op0[i];
            in_last = (i == n - 1);
            sum += 64'(op1[i]) * 64'(op0[i]);
        end
        e40 = sum[39:0];
        e32 = sum[31:0];
        eo40 = (sum >> 40) != 0;
        eo32 = (sum >> 32) != 0;
        @(negedge clk);
        checks++;
        if (rdy_a !== 1'b0 || rdy_b !== 1'b0 || ov_a !== 1'b0 || ov_b !== 1'b0) begin
            errors++;
            $display("FAIL %s drain: got rdy=%b/%b ov=%b/%b expected rdy=0 ov=0", name, rdy_a, rdy_b, ov_a, ov_b);
        end
        in_valid = 1'b1;
        number1 = 16'($urandom);
        number0 = 16'($urandom);
        in_last = 1'($urandom);
        @(negedge clk);
        checks++;
        if (ov_a !== 1'b1 || ov_b !== 1'b1 || rdy_a !== 1'b0 || rdy_b !== 1'b0) begin
            errors++;
            $display("FAIL %s out_valid: got ov=%b/%b rdy=%b/%b expected ov=1 rdy=0", name, ov_a, ov_b, rdy_a, rdy_b);
        end
        checks++;
        if (acc_a !== e40 || acc_b !== e32 || cnt_a !== 8'(n) || cnt_b !== 8'(n) || ovf_a !== eo40 || ovf_b !== eo32) begin
            errors++;
            $display("FAIL %s result: got acc=%0h/%0h cnt=%0d/%0d ovf=%b/%b expected acc=%0h/%0h cnt=%0d ovf=%b/%b",
                     name, acc_a, acc_b, cnt_a, cnt_b, ovf_a, ovf_b, e40, e32, 8'(n), eo40, eo32);
        end
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'($urandom);
            number1 = 16'($urandom);
            number0 = 16'($urandom);
            in_last = 1'($urandom);
            @(negedge clk);
            checks++;
            if (ov_a !== 1'b1 || rdy_a !== 1'b0 || acc_a !== e40 || acc_b !== e32 || cnt_a !== 8'(n) || ovf_b !== eo32) begin
                errors++;
                $display("FAIL %s hold%0d: got ov=%b rdy=%b acc=%0h/%0h cnt=%0d ovf=%b expected ov=1 rdy=0 acc=%0h/%0h cnt=%0d ovf=%b",
                         name, h, ov_a, rdy_a, acc_a, acc_b, cnt_a, ovf_b, e40, e32, 8'(n), eo32);
            end
        end
        out_ready = 1'b1;
        in_valid = 1'b1;
        in_last = 1'b1;
        @(negedge clk);
        checks++;
        if (ov_a !== 1'b0 || ov_b !== 1'b0 || rdy_a !== 1'b1 || rdy_b !== 1'b1 || acc_a !== 40'd0 || acc_b !== 32'd0 ||
            cnt_a !== 8'd0 || cnt_b !== 8'd0 || ovf_a !== 1'b0 || ovf_b !== 1'b0) begin
            errors++;
            $display("FAIL %s after_handshake: got ov=%b rdy=%b acc=%0h/%0h cnt=%0d/%0d ovf=%b/%b expected ov=0 rdy=1 all zero",
                     name, ov_a, rdy_a, acc_a, acc_b, cnt_a, cnt_b, ovf_a, ovf_b);
        end
        in_valid = 1'b0;
        in_last = 1'b0;
        @(negedge clk);
        checks++;
        if (acc_a !== 40'd0 || acc_b !== 32'd0 || cnt_a !== 8'd0 || cnt_b !== 8'd0) begin
            errors++;
            $display("FAIL %s no_stray_accept: got acc=%0h/%0h cnt=%0d/%0d expected 0", name, acc_a, acc_b, cnt_a, cnt_b);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if (rdy_a !== 1'b1 || ov_a !== 1'b0 || acc_a !== 40'd0 || cnt_a !== 8'd0 || ovf_a !== 1'b0 || rdy_b !== 1'b1) begin
            errors++;
            $display("FAIL reset_values: got rdy=%b ov=%b acc=%0h cnt=%0d ovf=%b expected rdy=1 ov=0 acc=0 cnt=0 ovf=0", rdy_a, ov_a, acc_a, cnt_a, ovf_a);
        end
        rst = 1'b0;
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_last = 1'b1;
        number1 = 16'd5;
        number0 = 16'd7;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (ov_a !== 1'b1 || acc_a !== 40'd35) begin
            errors++;
            $display("FAIL reset_prep: got ov=%b acc=%0h expected ov=1 acc=23", ov_a, acc_a);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (rdy_a !== 1'b1 || ov_a !== 1'b0 || acc_a !== 40'd0 || cnt_a !== 8'd0 || ovf_a !== 1'b0 || acc_b !== 32'd0) begin
            errors++;
            $display("FAIL async_reset: got rdy=%b ov=%b acc=%0h cnt=%0d ovf=%b expected rdy=1 ov=0 acc=0 cnt=0 ovf=0", rdy_a, ov_a, acc_a, cnt_a, ovf_a);
        end
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (rdy_a !== 1'b1 || ov_a !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: got rdy=%b ov=%b expected rdy=1 ov=0", rdy_a, ov_a);
        end
    endtask

    task automatic test_single();
        op1[0] = 16'd3; op0[0] = 16'd5;
        drive_vector("single", 1, 0);
    endtask

    task automatic test_four();
        for (int i = 0; i < 4; i++) begin
            op1[i] = 16'(2 * i + 1);
            op0[i] = 16'(2 * i + 2);
        end
        drive_vector("four_beat", 4, 0);
    endtask

    task automatic test_backpressure();
        op1[0] = 16'd6; op0[0] = 16'd7;
        op1[1] = 16'd9; op0[1] = 16'd11;
        drive_vector("backpressure", 2, 5);
        op1[0] = 16'd2; op0[0] = 16'd2;
        drive_vector("after_backpressure", 1, 0);
    endtask

    task automatic test_overflow();
        op1[0] = 16'hFFFF; op0[0] = 16'hFFFF;
        op1[1] = 16'hFFFF; op0[1] = 16'hFFFF;
        drive_vector("overflow", 2, 1);
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_last = 1'b0;
            number1 = 16'(9 - i);
            number0 = 16'(9 - i);
        end
        @(negedge clk);
        in_valid = 1'b0;
        #3 rst = 1'b1;
        #1;
        checks++;
        if (acc_a !== 40'd0 || cnt_a !== 8'd0 || ov_a !== 1'b0 || rdy_a !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid: got acc=%0h cnt=%0d ov=%b rdy=%b expected acc=0 cnt=0 ov=0 rdy=1", acc_a, cnt_a, ov_a, rdy_a);
        end
        @(negedge clk);
        rst = 1'b0;
        op1[0] = 16'd4; op0[0] = 16'd4;
        drive_vector("after_reset_mid", 1, 0);
    endtask

    task automatic test_cnt_wrap();
        for (int i = 0; i < 260; i++) begin
            op1[i] = 16'hFFFF;
            op0[i] = 16'hFFFF;
        end
        drive_vector("cnt_wrap", 260, 0);
    endtask

    task automatic test_random();
        for (int v = 0; v < 10; v++) begin
            int n;
            n = int'($urandom_range(1, 20));
            for (int i = 0; i < n; i++) begin
                op1[i] = 16'($urandom);
                op0[i] = 16'($urandom);
            end
            drive_vector("random", n, int'($urandom_range(0, 3)));
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_four();
        test_backpressure();
        test_overflow();
        test_reset_mid();
        test_cnt_wrap();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/wallace_mac.md
# wallace_mac

Sequential multiply-accumulate stage built directly around `wallace_mul`. It accepts a stream of 16-bit unsigned operand pairs over a valid/ready handshake and registers each pair in front of the multiplier. It accumulates the 32-bit products and presents one dot-product result per vector, where a vector is terminated by `in_last`. It is the clocked consumer of the combinational Wallace-tree product and the unit the datapath instantiates wherever a sum of products is needed.

## Interface
- `ACC_W`, default 40: accumulator and result width; must be ≥ 32.
- `CNT_W`, default 8: width of the beat counter.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  operand pair valid.
- `in_ready`  out  1  block can accept a pair this cycle.
- `number1`, `number0`  in  16 each  unsigned operands.
- `in_last`  in  1  this pair is the final term of the vector.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  downstream accepts the result.
- `acc_out`  out  ACC_W  dot-product result.
- `cnt_out`  out  CNT_W  number of terms in the vector; wraps modulo 2^CNT_W.
- `acc_ovf`  out  1  sticky flag: the accumulator wrapped during this vector.

## Operation
- Three-state FSM:
  - `RUN`: `in_ready`=1.
  - `DRAIN`: the last pair sits in the operand register.
  - `HOLD`: `out_valid`=1, waiting for downstream.
- Transitions:
  - `RUN`→`DRAIN` on an accepted beat with `in_last`=1.
  - `DRAIN`→`HOLD` unconditionally after one cycle.
  - `HOLD`→`RUN` on `out_valid & out_ready`.
- Operand register (S1) loads `number1`, `number0`, `in_last` and sets `s1_valid` on accept (`in_valid & in_ready`). Otherwise `s1_valid` clears.
- S1 feeds `wallace_mul`. Its `rst_n` is driven by `~rst`.
- Accumulate (S2): when `s1_valid`, `acc <= acc + zero_extend(q)` modulo 2^ACC_W, and `cnt` increments.
- `acc_ovf` sets on the carry out of bit ACC_W-1 and is otherwise held.
- `acc_out`, `cnt_out` and `acc_ovf` are direct register outputs. They are stable for the whole of `HOLD`.
- On the output handshake edge, `acc`, `cnt` and `acc_ovf` clear to 0 and the FSM returns to `RUN`.
- `in_valid` in `DRAIN`/`HOLD` is ignored; no beat is accepted.
- Reset value of every output: `in_ready`=1, `out_valid`=0, `acc_out`=0, `cnt_out`=0, `acc_ovf`=0. FSM resets to `RUN` and `s1_valid` to 0.

## Timing
- Throughput in `RUN` is one pair per cycle.
- Beat accepted at edge k is added to `acc` at edge k+1.
- Last beat accepted at edge k:
  - `in_ready` drops after edge k.
  - `out_valid` rises after edge k+1, i.e. visible 2 cycles after the last beat was presented.
- Minimum vector-to-vector spacing is 3 cycles when `out_ready` is held at 1.
- After the output handshake edge, `in_ready`=1 in the next cycle.
- Simultaneous events:
  - In `HOLD`, `in_valid` is ignored, and `out_ready` with `in_valid` does not accept a beat in the same cycle.
  - A single-beat vector (`in_last` on the first beat) is legal.
- Reset asserted mid-vector or in `HOLD` discards everything immediately and asynchronously. Outputs return to their reset values with no partial result emitted.
- The combinational path runs from the S1 register through the Wallace tree and the ACC_W-bit adder into `acc`; this is the critical path.

## Structure
- Shared package holds:
  - FSM state encoding (`RUN`/`DRAIN`/`HOLD`, 2 bits).
  - Default `ACC_W`, `CNT_W`.
  - Operand width constant 16.
- One sub-module: the existing `wallace_mul`, instantiated once and unmodified.
- The accumulate adder is inline.

## Test plan
- Reset:
  - Assert `rst` asynchronously mid-cycle → all outputs at reset values immediately.
  - Release → `in_ready`=1.
- Single beat (3, 5, last):
  - `out_valid` 2 cycles later, `acc_out`=15, `cnt_out`=1, `acc_ovf`=0.
- Four-beat vector (1,2),(3,4),(5,6),(7,8) back-to-back:
  - `acc_out`=100, `cnt_out`=4.
  - `in_ready`=0 from the cycle after the last beat until the handshake.
- Backpressure:
  - `out_ready`=0 for 5 cycles in `HOLD` → `acc_out`/`cnt_out` stable and `in_valid` pulses ignored.
  - After the handshake, next vector (2,2,last) → `acc_out`=4.
- Overflow with `ACC_W`=32: (0xFFFF,0xFFFF),(0xFFFF,0xFFFF,last):
  - `acc_out`=0xFFFC0002, `acc_ovf`=1.
  - Flag clears after the handshake.
- Reset mid-vector after 2 beats, then (4,4,last) → `acc_out`=16, `cnt_out`=1.
